// File: rtl/chacha_block_core_if.sv
// Valid/ready bundle for the ChaCha block engine: one 512-bit state in, one 512-bit state out.
// A transfer happens on a rising edge where valid and ready are both high; valid holds until then.
interface chacha_block_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_state;
    logic         in_ff;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, in_ff, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_ff, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: LANES quarter-rounds per cycle over ROUNDS rounds,
// optional feed-forward of the input state, valid/ready in and out.
module chacha_block_core #(
    parameter int ROUNDS = 20,
    parameter int LANES  = 1
) (
    input  logic                g_clk,
    input  logic                g_resetn,
    chacha_block_core_if.slave  bus,
    output logic [1:0]          dbg_state
);

    localparam int STEPS = ROUNDS * 4 / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(STEPS - 1);

    if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_bad_rounds
        $error("chacha_block_core: ROUNDS must be even and >= 2");
    end
    if ((LANES != 1) && (LANES != 2) && (LANES != 4)) begin : g_bad_lanes
        $error("chacha_block_core: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [31:0]   work_q [16];
    logic [31:0]   save_q [16];
    logic [31:0]   next_w [16];
    logic [CW-1:0] t_q;
    logic          ff_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic [511:0]  out_state_q;
    logic [511:0]  result_w;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // QR qi touches word 4k + col for k = 0..3; diagonals shift the column by k.
    function automatic logic [3:0] word_of(input logic [2:0] qi, input logic [1:0] k);
        logic [1:0] col;
        col = qi[1:0] + (qi[2] ? k : 2'd0);
        return {k, col};
    endfunction

    always_comb begin : qr_datapath
        logic [2:0]  base;
        logic [2:0]  qi;
        logic [3:0]  ia, ib, ic, id;
        logic [31:0] a, b, c, d;
        base = 3'(t_q * LANES);
        qi = '0;
        ia = '0; ib = '0; ic = '0; id = '0;
        a = '0; b = '0; c = '0; d = '0;
        next_w = work_q;
        for (int l = 0; l < LANES; l++) begin
            qi = base + 3'(l);
            ia = word_of(qi, 2'd0);
            ib = word_of(qi, 2'd1);
            ic = word_of(qi, 2'd2);
            id = word_of(qi, 2'd3);
            a = work_q[ia];
            b = work_q[ib];
            c = work_q[ic];
            d = work_q[id];
            a = a + b; d = rotl(d ^ a, 16);
            c = c + d; b = rotl(b ^ c, 12);
            a = a + b; d = rotl(d ^ a, 8);
            c = c + d; b = rotl(b ^ c, 7);
            next_w[ia] = a;
            next_w[ib] = b;
            next_w[ic] = c;
            next_w[id] = d;
        end
        result_w = '0;
        for (int i = 0; i < 16; i++) begin
            result_w[32*i +: 32] = ff_q ? (next_w[i] + save_q[i]) : next_w[i];
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            ff_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_state_q <= '0;
            for (int i = 0; i < 16; i++) begin
                work_q[i] <= '0;
                save_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            work_q[i] <= bus.in_state[32*i +: 32];
                            save_q[i] <= bus.in_state[32*i +: 32];
                        end
                        ff_q       <= bus.in_ff;
                        t_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    work_q <= next_w;
                    t_q    <= t_q + 1'b1;
                    if (t_q == T_LAST) begin
                        out_state_q <= result_w;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // in_ready stays low through the handshake edge so results never overlap.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Directed bench for chacha_block_core: RFC 7539 block across lane counts, zero/ff cases,
// backpressure, async reset mid-run and back-to-back blocks against a reference model.
module tb_chacha_block_core;

    localparam int N = 4;

    logic         g_clk;
    logic         g_resetn;
    logic         in_valid_a  [N];
    logic [511:0] in_state_a  [N];
    logic         in_ff_a     [N];
    logic         out_ready_a [N];
    logic         in_ready_a  [N];
    logic         out_valid_a [N];
    logic [511:0] out_state_a [N];
    logic         busy_a      [N];
    logic [1:0]   dbg_a       [N];

    int n_checks = 0;
    int n_errors = 0;
    logic [511:0] exp_q[$];

    // Instance g: 0 -> R20/L1, 1 -> R20/L2, 2 -> R20/L4, 3 -> R2/L4
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LN = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        localparam int RN = (g == 3) ? 2 : 20;
        chacha_block_core_if u_bus ();
        assign u_bus.in_valid  = in_valid_a[g];
        assign u_bus.in_state  = in_state_a[g];
        assign u_bus.in_ff     = in_ff_a[g];
        assign u_bus.out_ready = out_ready_a[g];
        assign in_ready_a[g]   = u_bus.in_ready;
        assign out_valid_a[g]  = u_bus.out_valid;
        assign out_state_a[g]  = u_bus.out_state;
        assign busy_a[g]       = u_bus.busy;
        chacha_block_core #(.ROUNDS(RN), .LANES(LN)) u_dut (
            .g_clk     (g_clk),
            .g_resetn  (g_resetn),
            .bus       (u_bus.slave),
            .dbg_state (dbg_a[g])
        );
    end

    // clock / reset
    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] ref_qr(input logic [31:0] a, b, c, d);
        a = a + b; d = d ^ a; d = rl(d, 16);
        c = c + d; b = b ^ c; b = rl(b, 12);
        a = a + b; d = d ^ a; d = rl(d, 8);
        c = c + d; b = b ^ c; b = rl(b, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] ref_block(input logic [511:0] s, input int rounds, input logic ff);
        logic [31:0]  x [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int k = 0; k < rounds; k += 2) begin
            {x[0], x[4], x[8],  x[12]} = ref_qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = ref_qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = ref_qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = ref_qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = ref_qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = ref_qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = ref_qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = ref_qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++)
            r[32*i +: 32] = ff ? (x[i] + s[32*i +: 32]) : x[i];
        return r;
    endfunction

    // RFC 7539 2.3.2 vectors
    logic [31:0] rfc_in_w [16] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
        32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    logic [31:0] rfc_out_w [16] = '{
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
    logic [511:0] rfc_in, rfc_out, rfc_noff;

    // checking
    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic send(input int i, input logic [511:0] s, input logic ff);
        check("accept_ready", 512'(in_ready_a[i]), 512'd1);
        in_state_a[i] = s;
        in_ff_a[i]    = ff;
        in_valid_a[i] = 1'b1;
        tick();
        in_valid_a[i] = 1'b0;
        in_state_a[i] = ~s;
        in_ff_a[i]    = ~ff;
    endtask

    task automatic wait_valid(input int i, input int budget, output int cyc);
        cyc = 0;
        while (!out_valid_a[i] && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic release_out(input int i);
        out_ready_a[i] = 1'b1;
        tick();
        out_ready_a[i] = 1'b0;
        check("release_in_ready", 512'(in_ready_a[i]), 512'd1);
        check("release_out_valid", 512'(out_valid_a[i]), 512'd0);
    endtask

    task automatic run_block(input int i, input logic [511:0] s, input logic ff,
                             input int steps, input logic [511:0] exp, input string tag);
        int cyc;
        send(i, s, ff);
        wait_valid(i, steps + 20, cyc);
        check({tag, "_latency"}, 512'(cyc), 512'(steps));
        check({tag, "_state"}, out_state_a[i], exp);
        check({tag, "_busy"}, 512'(busy_a[i]), 512'd1);
        release_out(i);
    endtask

    initial begin
        int steps_of [N] = '{80, 40, 20, 2};
        logic [511:0] held, ra, rb, got;
        int cyc, accepts, results, first_t, second_t;
        logic pre_rdy;

        for (int w = 0; w < 16; w++) begin
            rfc_in[32*w +: 32]   = rfc_in_w[w];
            rfc_out[32*w +: 32]  = rfc_out_w[w];
            rfc_noff[32*w +: 32] = rfc_out_w[w] - rfc_in_w[w];
        end
        for (int i = 0; i < N; i++) begin
            in_valid_a[i] = 1'b0; in_state_a[i] = '0; in_ff_a[i] = 1'b0; out_ready_a[i] = 1'b0;
        end

        g_resetn = 1'b0;
        tick(); tick();
        for (int i = 0; i < N; i++) begin
            check("rst_in_ready", 512'(in_ready_a[i]), 512'd1);
            check("rst_out_valid", 512'(out_valid_a[i]), 512'd0);
            check("rst_busy", 512'(busy_a[i]), 512'd0);
            check("rst_out_state", out_state_a[i], 512'd0);
            check("rst_fsm_idle", 512'(dbg_a[i]), 512'd0);
        end
        g_resetn = 1'b1;
        tick();

        // RFC block with feed-forward on every lane count
        check("model_rfc", ref_block(rfc_in, 20, 1'b1), rfc_out);
        run_block(0, rfc_in, 1'b1, 80, rfc_out, "rfc_l1");
        check("rfc_l1_w0_3", 512'(out_state_a[0][127:0]), 512'(128'hc47120a3_1fdd0f50_15593bd1_e4e7f110));
        run_block(1, rfc_in, 1'b1, 40, rfc_out, "rfc_l2");
        run_block(2, rfc_in, 1'b1, 20, rfc_out, "rfc_l4");
        run_block(3, rfc_in, 1'b1, steps_of[3], ref_block(rfc_in, 2, 1'b1), "rfc_r2_l4");

        // zero input and no-feed-forward
        run_block(2, 512'd0, 1'b0, 20, 512'd0, "zero_noff");
        run_block(2, 512'd0, 1'b1, 20, 512'd0, "zero_ff");
        run_block(2, rfc_in, 1'b0, 20, rfc_noff, "rfc_noff");

        // backpressure with an ignored in_valid pulse
        send(2, rfc_in, 1'b1);
        wait_valid(2, 40, cyc);
        check("bp_latency", 512'(cyc), 512'd20);
        held = out_state_a[2];
        check("bp_state", held, rfc_out);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) begin
                in_state_a[2] = 512'd0;
                in_valid_a[2] = 1'b1;
            end else begin
                in_valid_a[2] = 1'b0;
            end
            tick();
            check("bp_hold_state", out_state_a[2], held);
            check("bp_hold_valid", 512'(out_valid_a[2]), 512'd1);
            check("bp_hold_in_ready", 512'(in_ready_a[2]), 512'd0);
        end
        in_valid_a[2] = 1'b0;
        release_out(2);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_pulse_ignored", 512'(busy_a[2]), 512'd0);
        end

        // async reset in the middle of RUN
        send(0, rfc_in, 1'b1);
        for (int k = 0; k < 40; k++) tick();
        check("mid_busy_before_rst", 512'(busy_a[0]), 512'd1);
        g_resetn = 1'b0;
        #1;
        check("arst_in_ready", 512'(in_ready_a[0]), 512'd1);
        check("arst_out_valid", 512'(out_valid_a[0]), 512'd0);
        check("arst_busy", 512'(busy_a[0]), 512'd0);
        check("arst_out_state", out_state_a[0], 512'd0);
        #2;
        g_resetn = 1'b1;
        tick();
        run_block(0, rfc_in, 1'b1, 80, rfc_out, "post_rst");

        // back-to-back random states, out_ready held high
        for (int w = 0; w < 16; w++) begin
            ra[32*w +: 32] = $urandom();
            rb[32*w +: 32] = $urandom();
        end
        exp_q.push_back(ref_block(ra, 20, 1'b1));
        exp_q.push_back(ref_block(rb, 20, 1'b1));
        out_ready_a[2] = 1'b1;
        in_state_a[2]  = ra;
        in_ff_a[2]     = 1'b1;
        in_valid_a[2]  = 1'b1;
        accepts = 0; results = 0; first_t = 0; second_t = 0; cyc = 0;
        while (results < 2 && cyc < 200) begin
            pre_rdy = in_ready_a[2];
            tick();
            cyc++;
            if (pre_rdy && in_valid_a[2]) begin
                accepts++;
                if (accepts == 1) in_state_a[2] = rb;
                else in_valid_a[2] = 1'b0;
            end
            if (out_valid_a[2]) begin
                results++;
                got = exp_q.pop_front();
                check("b2b_state", out_state_a[2], got);
                if (results == 1) first_t = cyc; else second_t = cyc;
            end
        end
        in_valid_a[2]  = 1'b0;
        out_ready_a[2] = 1'b0;
        check("b2b_results", 512'(results), 512'd2);
        check("b2b_gap", 512'(second_t - first_t), 512'd22);
        check("b2b_queue_empty", 512'(exp_q.size()), 512'd0);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/chacha_block_core.md
# chacha_block_core

Iterative, parametrised ChaCha block-function engine that generalises the single-step quarter-round datapath to a complete 16-word state permutation. It runs a configurable number of rounds with a configurable number of parallel quarter-round lanes, applies an optional feed-forward addition, and exchanges 512-bit states over valid/ready handshakes. It sits beside the ChaCha ISE units as a standalone accelerator that keystream and coprocessor wrappers can call.

## Interface

Parameters:
- ROUNDS, 20: number of ChaCha rounds. Must be even and at least 2; any other value is an elaboration error.
- LANES, 1: quarter-rounds evaluated per cycle. Must be 1, 2 or 4; any other value is an elaboration error.

Ports:
- g_clk  in  1  clock, rising edge.
- g_resetn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input state offered.
- in_ready  out  1  core can accept an input state.
- in_state  in  512  input state; word i is in_state[32i+31:32i].
- in_ff  in  1  when 1, add the saved input state to the result (feed-forward).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_state  out  512  result state, same word packing as in_state.
- busy  out  1  high in RUN and DONE.

## Operation

- Quarter-round QR(a,b,c,d): a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7. All arithmetic is mod 2^32.
- QR indices 0..7:
  - Column QRs: 0=(0,4,8,12), 1=(1,5,9,13), 2=(2,6,10,14), 3=(3,7,11,15).
  - Diagonal QRs: 4=(0,5,10,15), 5=(1,6,11,12), 6=(2,7,8,13), 7=(3,4,9,14).
- Round r (counting from 0) uses the column set when r is even and the diagonal set when r is odd.
- Step counter t runs from 0 to STEPS-1, where STEPS = ROUNDS*4/LANES.
  - Cycle t applies QR indices (t*LANES mod 8) through +LANES-1.
  - Those lanes touch disjoint words and are evaluated in parallel from the current working state.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid=1, load the working state and the saved copy from in_state, latch in_ff, set t=0, and go to RUN.
  - RUN: in_ready=0. Each cycle the working state takes the QR-updated value and t increments.
  - On the cycle with t=STEPS-1: out_state is registered as next_state + saved (wordwise mod 2^32) if the latched ff is 1, otherwise next_state. The FSM then goes to DONE.
  - DONE: out_valid=1 and out_state is held stable. When out_ready=1, go to IDLE.
- No overlap between results: in_ready is low in DONE, including the cycle in which out_ready is sampled high. in_ready returns the cycle after the output handshake.
- in_ff and in_state are sampled only at the accept edge. Changes at any other time have no effect.

## Timing

- Reset values: in_ready=1, out_valid=0, busy=0, out_state=0. Working state, saved state, t and latched ff are all 0, and the FSM is in IDLE.
- Latency: for an input accepted at edge k, out_valid rises after edge k+STEPS.
  - LANES=1, ROUNDS=20: 80 cycles.
  - LANES=4, ROUNDS=20: 20 cycles.
  - LANES=2, ROUNDS=8: 16 cycles.
- Throughput: one block every STEPS+2 cycles when out_ready is held at 1.
- Backpressure: while out_valid=1 and out_ready=0, out_state, out_valid and busy hold indefinitely.
- Reset mid-operation (RUN or DONE): all outputs drop to their reset values immediately. The in-flight block is discarded and no stale out_valid appears after reset is released.
- in_valid in RUN or DONE is ignored; the offer is not queued.
- Counter width is clog2(STEPS) with a minimum of 1. STEPS=2 (ROUNDS=2, LANES=4) must work.

## Test plan

- RFC 7539 §2.3.2 block, ROUNDS=20, in_ff=1, each of LANES=1/2/4.
  - Input words: 61707865 3320646e 79622d32 6b206574 03020100 07060504 0b0a0908 0f0e0d0c 13121110 17161514 1b1a1918 1f1e1d1c 00000001 09000000 4a000000 00000000.
  - Required output words 0..3: e4e7f110 15593bd1 1fdd0f50 c47120a3. Full 16 words must match the golden model, with out_valid at exactly 80/40/20 cycles after accept.
- All-zero input, in_ff=0 and in_ff=1, any parameters -> all-zero out_state.
- Same RFC input with in_ff=0 -> out_state equals (RFC output minus input) wordwise mod 2^32.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_state stable and in_ready=0 throughout. Pulse in_valid during the hold -> ignored. Raise out_ready -> in_ready=1 on the next cycle.
- Async reset: assert g_resetn=0 halfway through RUN -> outputs immediately at reset values. A fresh RFC input accepted after release -> correct result with no spurious earlier out_valid.
- Back-to-back: two different random states with out_ready=1 -> both results match the golden model, and the second out_valid comes STEPS+2 cycles after the first.
